onehot_prio_select: RTL and testbench

// - Strict-priority one-hot grant generator plus AND-OR one-hot data mux, the arbitration core of the AHBL N:1 arbiter.
// - Converts a request vector into a one-hot grant (lowest index wins) and routes the granted lane of a packed data bus.
// - Also exposes a standalone select input for a second mux path (data-phase hwdata style).
// - Combinational datapath; one registered grant copy for data-phase tracking.

---
 rtl/onehot_prio_select_pkg.sv | 8 +
 rtl/onehot_prio_select_if.sv | 30 +++
 rtl/onehot_andor_mux.sv | 22 ++
 rtl/onehot_priority_core.sv | 14 +
 rtl/onehot_prio_select.sv | 69 ++++++
 tb/tb_onehot_prio_select.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/onehot_prio_select_pkg.sv
// Shared defaults for the one-hot priority select block.
// Holds the default lane count and lane width used by the interface and the top.
package onehot_prio_select_pkg;

  localparam int unsigned DefNInputs = 2;
  localparam int unsigned DefWInput  = 32;

endpackage

// File: rtl/onehot_prio_select_if.sv
// Bus bundle for onehot_prio_select.
// master: drives req/adv/din/sel_ext, observes gnt/gnt_q/dout/dout_ext.
// slave : the select block itself.
interface onehot_prio_select_if
  import onehot_prio_select_pkg::*;
#(
  parameter int unsigned N_INPUTS = DefNInputs,
  parameter int unsigned W_INPUT  = DefWInput
);

  logic [N_INPUTS-1:0]         req;
  logic [N_INPUTS-1:0]         gnt;
  logic [N_INPUTS-1:0]         gnt_q;
  logic                        adv;
  logic [N_INPUTS*W_INPUT-1:0] din;
  logic [W_INPUT-1:0]          dout;
  logic [N_INPUTS-1:0]         sel_ext;
  logic [W_INPUT-1:0]          dout_ext;

  modport master (
    output req, adv, din, sel_ext,
    input  gnt, gnt_q, dout, dout_ext
  );

  modport slave (
    input  req, adv, din, sel_ext,
    output gnt, gnt_q, dout, dout_ext
  );

endinterface

// File: rtl/onehot_andor_mux.sv
// AND-OR mux over packed lanes. Multiple select bits yield the OR of those lanes,
// no select bit yields zero.
// Ports: in_i  - packed lanes, lane i at [i*W_INPUT +: W_INPUT]
//        sel_i - lane select vector
//        out_o - selected data
module onehot_andor_mux #(
  parameter int unsigned W_INPUT  = 32,
  parameter int unsigned N_INPUTS = 2
) (
  input  logic [N_INPUTS*W_INPUT-1:0] in_i,
  input  logic [N_INPUTS-1:0]         sel_i,
  output logic [W_INPUT-1:0]          out_o
);

  always_comb begin
    out_o = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      out_o |= in_i[i*W_INPUT +: W_INPUT] & {W_INPUT{sel_i[i]}};
    end
  end

endmodule

// File: rtl/onehot_priority_core.sv
// Strict-priority encoder: the lowest set bit of in_i is passed to out_o.
// Ports: in_i  - request vector (W_INPUT lanes)
//        out_o - one-hot grant, zero when in_i is zero
module onehot_priority_core #(
  parameter int unsigned W_INPUT = 2
) (
  input  logic [W_INPUT-1:0] in_i,
  output logic [W_INPUT-1:0] out_o
);

  // Two's-complement trick isolates the lowest set bit; zero stays zero.
  assign out_o = in_i & (~in_i + W_INPUT'(1));

endmodule

// File: rtl/onehot_prio_select.sv
// Arbitration core: lowest-index-wins one-hot grant, granted-lane data mux,
// an external-select mux, and a registered grant copy for data-phase tracking.
// Ports: clk   - system clock
//        rst_n - asynchronous active-low reset (clears gnt_q only)
//        bus   - onehot_prio_select_if slave (req/adv/din/sel_ext in,
//                gnt/gnt_q/dout/dout_ext out)
module onehot_prio_select
  import onehot_prio_select_pkg::*;
#(
  parameter int unsigned N_INPUTS = DefNInputs,
  parameter int unsigned W_INPUT  = DefWInput
) (
  input logic               clk,
  input logic               rst_n,
  onehot_prio_select_if.slave bus
);

  logic [N_INPUTS-1:0] gnt;
  logic [N_INPUTS-1:0] gnt_q_d, gnt_q_q;
  logic [W_INPUT-1:0]  dout;
  logic [W_INPUT-1:0]  dout_ext;

  onehot_priority_core #(
    .W_INPUT (N_INPUTS)
  ) u_core (
    .in_i  (bus.req),
    .out_o (gnt)
  );

  onehot_andor_mux #(
    .W_INPUT  (W_INPUT),
    .N_INPUTS (N_INPUTS)
  ) u_mux_gnt (
    .in_i  (bus.din),
    .sel_i (gnt),
    .out_o (dout)
  );

  onehot_andor_mux #(
    .W_INPUT  (W_INPUT),
    .N_INPUTS (N_INPUTS)
  ) u_mux_ext (
    .in_i  (bus.din),
    .sel_i (bus.sel_ext),
    .out_o (dout_ext)
  );

  // adv is the bus ready: capture the address-phase grant only when it advances.
  always_comb begin
    gnt_q_d = gnt_q_q;
    if (bus.adv) begin
      gnt_q_d = gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q_q <= '0;
    end else begin
      gnt_q_q <= gnt_q_d;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.gnt_q    = gnt_q_q;
  assign bus.dout     = dout;
  assign bus.dout_ext = dout_ext;

endmodule

// File: tb/tb_onehot_prio_select.sv
module tb_onehot_prio_select;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  onehot_prio_select_if #(.N_INPUTS(2), .W_INPUT(32)) b2 ();
  onehot_prio_select_if #(.N_INPUTS(4), .W_INPUT(16)) b4 ();

  onehot_prio_select #(.N_INPUTS(2), .W_INPUT(32)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  onehot_prio_select #(.N_INPUTS(4), .W_INPUT(16)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  // Reference: first requesting lane scanning upward from lane 0.
  function automatic logic [3:0] ref_gnt(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      if (r[i]) return 4'(1 << i);
    end
    return 4'b0;
  endfunction

  // Reference: OR of every lane whose select bit is set.
  function automatic logic [31:0] ref_mux(input logic [127:0] d, input logic [3:0] s,
                                         input int n, input int w);
    logic [31:0] acc;
    logic [31:0] mask;
    acc  = '0;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int i = 0; i < n; i++) begin
      if (s[i]) acc |= 32'(d >> (i * w)) & mask;
    end
    return acc;
  endfunction

  task automatic test_reset();
    b2.req = '0; b2.adv = 1'b1; b2.din = '0; b2.sel_ext = '0;
    b4.req = '0; b4.adv = 1'b1; b4.din = '0; b4.sel_ext = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b2.gnt_q !== 2'b00) begin
      errors++; $display("FAIL reset_gnt_q2 got %b want 00", b2.gnt_q);
    end
    checks++;
    if (b4.gnt_q !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt_q4 got %b want 0000", b4.gnt_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    @(negedge clk);
    b2.din = {32'hBBBB0001, 32'hAAAA0000};
    b2.req = 2'b11;
    #1;
    checks++;
    if (b2.gnt !== 2'b01 || b2.dout !== 32'hAAAA0000) begin
      errors++; $display("FAIL dir_req11 got gnt=%b dout=%h want 01 AAAA0000", b2.gnt, b2.dout);
    end
    b2.req = 2'b10;
    #1;
    checks++;
    if (b2.gnt !== 2'b10 || b2.dout !== 32'hBBBB0001) begin
      errors++; $display("FAIL dir_req10 got gnt=%b dout=%h want 10 BBBB0001", b2.gnt, b2.dout);
    end
    b2.req = 2'b00;
    #1;
    checks++;
    if (b2.gnt !== 2'b00 || b2.dout !== 32'h0) begin
      errors++; $display("FAIL dir_req00 got gnt=%b dout=%h want 00 0", b2.gnt, b2.dout);
    end
  endtask

  task automatic test_sweep4();
    logic [3:0] r;
    logic [3:0] eg;
    b4.din = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int v = 0; v < 16; v++) begin
      r = 4'(v);
      b4.req = r;
      #1;
      eg = ref_gnt(r, 4);
      checks++;
      if (b4.gnt !== eg || $countones(b4.gnt) > 1) begin
        errors++; $display("FAIL sweep4 req=%b got %b want %b", r, b4.gnt, eg);
      end
      checks++;
      if (b4.dout !== 16'(ref_mux(128'(b4.din), eg, 4, 16))) begin
        errors++; $display("FAIL sweep4_dout req=%b got %h", r, b4.dout);
      end
    end
    b4.req = '0;
  endtask

  task automatic test_ext();
    b2.din = {32'h0000_0F0F, 32'hF0F0_0000};
    b2.sel_ext = 2'b11;
    #1;
    checks++;
    if (b2.dout_ext !== 32'hF0F0_0F0F) begin
      errors++; $display("FAIL ext_both got %h want F0F00F0F", b2.dout_ext);
    end
    b2.sel_ext = 2'b00;
    #1;
    checks++;
    if (b2.dout_ext !== 32'h0) begin
      errors++; $display("FAIL ext_zero got %h want 0", b2.dout_ext);
    end
    b2.sel_ext = 2'b10;
    #1;
    checks++;
    if (b2.dout_ext !== 32'h0000_0F0F) begin
      errors++; $display("FAIL ext_lane1 got %h want 00000F0F", b2.dout_ext);
    end
  endtask

  task automatic test_gnt_q();
    @(negedge clk);
    b2.req = 2'b10; b2.adv = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b2.gnt_q !== 2'b10) begin
      errors++; $display("FAIL gntq_load got %b want 10", b2.gnt_q);
    end
    @(negedge clk);
    b2.req = 2'b01; b2.adv = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b2.gnt_q !== 2'b10) begin
      errors++; $display("FAIL gntq_hold got %b want 10", b2.gnt_q);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    b2.req = 2'b10; b2.adv = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b2.gnt_q !== 2'b00) begin
      errors++; $display("FAIL rst_async got %b want 00", b2.gnt_q);
    end
    b2.din = {32'h1234_5678, 32'h9ABC_DEF0};
    b2.req = 2'b11;
    #1;
    checks++;
    if (b2.gnt !== 2'b01 || b2.dout !== 32'h9ABC_DEF0) begin
      errors++; $display("FAIL rst_comb_live got gnt=%b dout=%h want 01 9ABCDEF0", b2.gnt, b2.dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    b2.adv = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b2.gnt_q !== 2'b00) begin
      errors++; $display("FAIL rst_release_hold got %b want 00", b2.gnt_q);
    end
    @(negedge clk);
    b2.adv = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b2.gnt_q !== 2'b01) begin
      errors++; $display("FAIL rst_release_load got %b want 01", b2.gnt_q);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_q2;
    logic [3:0] exp_q4;
    logic [3:0] eg2, eg4;
    exp_q2 = '0;
    exp_q4 = '0;
    for (int it = 0; it < 200; it++) begin
      @(negedge clk);
      b2.req     = 2'($urandom);
      b2.sel_ext = 2'($urandom);
      b2.din     = {$urandom, $urandom};
      b2.adv     = (it == 0) ? 1'b1 : 1'($urandom);
      b4.req     = 4'($urandom);
      b4.sel_ext = 4'($urandom);
      b4.din     = {$urandom, $urandom};
      b4.adv     = (it == 0) ? 1'b1 : 1'($urandom);
      #1;
      eg2 = ref_gnt({2'b00, b2.req}, 2);
      eg4 = ref_gnt(b4.req, 4);
      checks++;
      if (b2.gnt !== eg2[1:0] || b2.dout !== ref_mux(128'(b2.din), eg2, 2, 32)
          || b2.dout_ext !== ref_mux(128'(b2.din), {2'b00, b2.sel_ext}, 2, 32)) begin
        errors++;
        $display("FAIL rand2 req=%b sel=%b got gnt=%b dout=%h ext=%h want gnt=%b", b2.req,
                 b2.sel_ext, b2.gnt, b2.dout, b2.dout_ext, eg2[1:0]);
      end
      checks++;
      if (b4.gnt !== eg4 || b4.dout !== 16'(ref_mux(128'(b4.din), eg4, 4, 16))
          || b4.dout_ext !== 16'(ref_mux(128'(b4.din), b4.sel_ext, 4, 16))) begin
        errors++;
        $display("FAIL rand4 req=%b sel=%b got gnt=%b dout=%h ext=%h want gnt=%b", b4.req,
                 b4.sel_ext, b4.gnt, b4.dout, b4.dout_ext, eg4);
      end
      if (b2.adv) exp_q2 = eg2[1:0];
      if (b4.adv) exp_q4 = eg4;
      @(posedge clk); #1;
      checks++;
      if (b2.gnt_q !== exp_q2 || b4.gnt_q !== exp_q4) begin
        errors++;
        $display("FAIL rand_gntq got %b/%b want %b/%b", b2.gnt_q, b4.gnt_q, exp_q2, exp_q4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep4();
    test_ext();
    test_gnt_q();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
